// File: rtl/pulse_period_meter.sv
`default_nettype none
// ============================================================================
// Module   : pulse_period_meter
// Purpose  : Measures the period of a slow asynchronous square wave in cycles
//            of clk. The input is synchronised, rising edges are detected, and
//            the clk-cycle distance between consecutive rising edges is
//            published with a one-cycle valid strobe. Loss of signal is
//            flagged with a sticky timeout.
// Option   : define PERIOD_AVG_EN to report the floor of the mean of the last
//            four raw measurements instead of the raw measurement.
// Ports    : clk          - system clock, all logic on posedge
//            rst          - asynchronous active-high reset
//            sig_in       - asynchronous slow input being measured
//            clear        - synchronous soft clear (pulse or level)
//            period       - last measured rising-to-rising distance (CNT_W)
//            period_valid - one-cycle strobe, period updated this cycle
//            locked       - a valid measurement exists since reset/clear/timeout
//            timeout      - no rising edge for TIMEOUT cycles (sticky)
// Revision : 1.0 - initial release
// ============================================================================
module pulse_period_meter #(
  parameter int CNT_W       = 26,
  parameter int TIMEOUT     = 50_000_000,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             clear,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] C_TIMEOUT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] C_ONE     = CNT_W'(1);

  generate
    if (SYNC_STAGES < 2) begin : g_sync_stages_check
      $error("pulse_period_meter: SYNC_STAGES must be at least 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_TMO     = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_s_d;
  logic                   w_s;
  logic                   w_rise;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       w_cnt_nxt;
  logic [CNT_W-1:0]       r_period;
  logic [CNT_W-1:0]       w_period_new;
  logic                   r_valid;
  logic                   w_valid_nxt;
  logic                   r_locked;
  logic                   w_locked_nxt;
  logic                   r_timeout;
  logic                   w_timeout_nxt;
  logic                   w_meas;      // a complete period ends this cycle
  logic                   w_hist_clr;  // clear or timeout wipes averaging history

  // --------------------------------------------------------------------------
  // Input synchroniser and rising-edge detector
  // --------------------------------------------------------------------------
  assign w_s    = r_sync[SYNC_STAGES-1];
  assign w_rise = w_s & ~r_s_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
      r_s_d  <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], sig_in};
      r_s_d  <= w_s;
    end
  end

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next-state and next-value logic; clear outranks everything
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_valid_nxt   = 1'b0;
    w_locked_nxt  = r_locked;
    w_timeout_nxt = r_timeout;
    w_meas        = 1'b0;
    w_hist_clr    = 1'b0;

    if (clear) begin
      w_state_nxt   = ST_IDLE;
      w_cnt_nxt     = '0;
      w_locked_nxt  = 1'b0;
      w_timeout_nxt = 1'b0;
      w_hist_clr    = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // First edge only starts the count; no period exists yet.
          w_cnt_nxt = '0;
          if (w_rise) begin
            w_cnt_nxt   = C_ONE;
            w_state_nxt = ST_MEASURE;
          end
        end
        ST_MEASURE: begin
          // A rise on the cycle cnt reaches TIMEOUT still counts as a period.
          if (w_rise) begin
            w_meas       = 1'b1;
            w_valid_nxt  = 1'b1;
            w_locked_nxt = 1'b1;
            w_cnt_nxt    = C_ONE;
          end else if (r_cnt == C_TIMEOUT) begin
            w_state_nxt   = ST_TMO;
            w_timeout_nxt = 1'b1;
            w_locked_nxt  = 1'b0;
            w_hist_clr    = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + C_ONE;
          end
        end
        ST_TMO: begin
          // Recovery edge restarts counting; locked waits for a full period.
          if (w_rise) begin
            w_timeout_nxt = 1'b0;
            w_cnt_nxt     = C_ONE;
            w_state_nxt   = ST_MEASURE;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Reported value: raw count or running average of the last four counts
  // --------------------------------------------------------------------------
`ifdef PERIOD_AVG_EN
  // Only the three previous measurements are stored; the fourth term of the
  // average is the measurement completing now. Preloading all history slots
  // with the first value is equivalent to reporting that value unchanged.
  logic [CNT_W-1:0] r_hist [0:2];
  logic [CNT_W+1:0] w_sum;

  always_comb begin
    w_sum = '0;
    if (!r_locked) begin
      w_sum = {r_cnt, 2'b00};
    end else begin
      w_sum = (CNT_W+2)'(r_cnt) + (CNT_W+2)'(r_hist[0]) +
              (CNT_W+2)'(r_hist[1]) + (CNT_W+2)'(r_hist[2]);
    end
  end

  assign w_period_new = w_sum[CNT_W+1:2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hist[0] <= '0;
      r_hist[1] <= '0;
      r_hist[2] <= '0;
    end else if (w_hist_clr) begin
      r_hist[0] <= '0;
      r_hist[1] <= '0;
      r_hist[2] <= '0;
    end else if (w_meas) begin
      if (!r_locked) begin
        r_hist[0] <= r_cnt;
        r_hist[1] <= r_cnt;
        r_hist[2] <= r_cnt;
      end else begin
        r_hist[0] <= r_cnt;
        r_hist[1] <= r_hist[0];
        r_hist[2] <= r_hist[1];
      end
    end
  end
`else
  assign w_period_new = r_cnt;
`endif

  // --------------------------------------------------------------------------
  // Counter and registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_period  <= '0;
      r_valid   <= 1'b0;
      r_locked  <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_valid   <= w_valid_nxt;
      r_locked  <= w_locked_nxt;
      r_timeout <= w_timeout_nxt;
      if (clear) begin
        r_period <= '0;
      end else if (w_meas) begin
        r_period <= w_period_new;
      end
    end
  end

  assign period       = r_period;
  assign period_valid = r_valid;
  assign locked       = r_locked;
  assign timeout      = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_pulse_period_meter.sv
`default_nettype none
// ============================================================================
// Module   : tb_pulse_period_meter
// Purpose  : Directed self-checking bench for pulse_period_meter with
//            CNT_W=8, TIMEOUT=100, SYNC_STAGES=2. Expected averages are
//            selected when PERIOD_AVG_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pulse_period_meter;

  localparam int CNT_W = 8;

`ifdef PERIOD_AVG_EN
  localparam int E2_FIRST = 21;
  localparam int E2_LAST  = 29;
  localparam int E4A_LAST = 60;
  localparam int E4B_LAST = 80;
`else
  localparam int E2_FIRST = 25;
  localparam int E2_LAST  = 37;
  localparam int E4A_LAST = 100;
  localparam int E4B_LAST = 100;
`endif

  logic             clk;
  logic             rst;
  logic             sig_in;
  logic             clear;
  logic [CNT_W-1:0] period;
  logic             period_valid;
  logic             locked;
  logic             timeout;

  int total = 0;
  int bad   = 0;

  // Strobe monitor state
  int         vcnt;
  logic [7:0] first_p;
  logic [7:0] last_p;
  logic [7:0] vlog [0:7];
  bit         vdouble;
  bit         tmo_seen;
  bit         unlocked_valid;
  logic       prev_valid;

  pulse_period_meter #(
    .CNT_W       (CNT_W),
    .TIMEOUT     (100),
    .SYNC_STAGES (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sig_in       (sig_in),
    .clear        (clear),
    .period       (period),
    .period_valid (period_valid),
    .locked       (locked),
    .timeout      (timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    vcnt = 0; first_p = '0; last_p = '0; vdouble = 0; tmo_seen = 0;
    unlocked_valid = 0; prev_valid = 1'b0;
    for (int i = 0; i < 8; i++) vlog[i] = '0;
  end

  always @(negedge clk) begin
    if (period_valid === 1'b1) begin
      if (vcnt == 0) first_p = period;
      if (vcnt < 8) vlog[vcnt] = period;
      last_p = period;
      vcnt   = vcnt + 1;
      if (locked !== 1'b1) unlocked_valid = 1;
      if (prev_valid === 1'b1) vdouble = 1;
    end
    if (timeout === 1'b1) tmo_seen = 1;
    prev_valid = period_valid;
  end

  task automatic mon_reset();
    vcnt = 0; first_p = '0; last_p = '0; vdouble = 0; tmo_seen = 0;
    unlocked_valid = 0;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // n rising edges, each gap clk cycles after the previous; returns gap
  // cycles after the last rising edge.
  task automatic gen_edges(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      sig_in = 1'b1;
      tick(gap / 2);
      sig_in = 1'b0;
      tick(gap - gap / 2);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; sig_in = 1'b0; clear = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (period !== 8'd0) begin bad++; $display("FAIL rst_period: got %0d want 0", period); end
    total++; if (period_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", period_valid); end
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL rst_locked: got %b want 0", locked); end
    total++; if (timeout !== 1'b0) begin bad++; $display("FAIL rst_timeout: got %b want 0", timeout); end
    rst = 1'b0;
    tick(3);
  endtask

  task automatic test_square20();
    mon_reset();
    gen_edges(1, 20);
    total++; if (vcnt !== 0) begin bad++; $display("FAIL sq20_first_edge_valids: got %0d want 0", vcnt); end
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL sq20_locked_early: got %b want 0", locked); end
    gen_edges(4, 20);
    total++; if (vcnt !== 4) begin bad++; $display("FAIL sq20_valid_cnt: got %0d want 4", vcnt); end
    total++; if (first_p !== 8'd20) begin bad++; $display("FAIL sq20_first_period: got %0d want 20", first_p); end
    total++; if (last_p !== 8'd20) begin bad++; $display("FAIL sq20_last_period: got %0d want 20", last_p); end
    total++; if (vlog[1] !== 8'd20) begin bad++; $display("FAIL sq20_second_period: got %0d want 20", vlog[1]); end
    total++; if (period !== 8'd20) begin bad++; $display("FAIL sq20_period_hold: got %0d want 20", period); end
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL sq20_locked: got %b want 1", locked); end
    total++; if (vdouble !== 1'b0) begin bad++; $display("FAIL sq20_valid_width: got %b want 0", vdouble); end
    total++; if (unlocked_valid !== 1'b0) begin bad++; $display("FAIL sq20_valid_unlocked: got %b want 0", unlocked_valid); end
  endtask

  task automatic test_change37();
    mon_reset();
    tick(5);
    gen_edges(3, 37);
    total++; if (vcnt !== 3) begin bad++; $display("FAIL chg37_valid_cnt: got %0d want 3", vcnt); end
    total++; if (first_p !== 8'(E2_FIRST)) begin bad++; $display("FAIL chg37_first_period: got %0d want %0d", first_p, E2_FIRST); end
    total++; if (last_p !== 8'(E2_LAST)) begin bad++; $display("FAIL chg37_last_period: got %0d want %0d", last_p, E2_LAST); end
  endtask

  task automatic test_timeout();
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    tick(3);
    mon_reset();
    sig_in = 1'b1;
    for (int k = 1; k <= 102; k++) begin
      @(posedge clk);
      #1;
      if (k == 10) sig_in = 1'b0;
    end
    total++; if (timeout !== 1'b0) begin bad++; $display("FAIL tmo_early: got %b want 0", timeout); end
    tick(1);
    total++; if (timeout !== 1'b1) begin bad++; $display("FAIL tmo_set: got %b want 1", timeout); end
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL tmo_locked: got %b want 0", locked); end
    total++; if (period !== 8'd0) begin bad++; $display("FAIL tmo_period: got %0d want 0", period); end
    total++; if (vcnt !== 0) begin bad++; $display("FAIL tmo_valid_cnt: got %0d want 0", vcnt); end
    gen_edges(1, 20);
    total++; if (timeout !== 1'b0) begin bad++; $display("FAIL tmo_recover: got %b want 0", timeout); end
    total++; if (vcnt !== 0) begin bad++; $display("FAIL tmo_recover_valids: got %0d want 0", vcnt); end
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL tmo_recover_locked: got %b want 0", locked); end
    gen_edges(1, 20);
    total++; if (vcnt !== 1) begin bad++; $display("FAIL tmo_after_valid_cnt: got %0d want 1", vcnt); end
    total++; if (last_p !== 8'd20) begin bad++; $display("FAIL tmo_after_period: got %0d want 20", last_p); end
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL tmo_after_locked: got %b want 1", locked); end
  endtask

  task automatic test_boundary();
    mon_reset();
    gen_edges(3, 100);
    total++; if (vcnt !== 3) begin bad++; $display("FAIL bnd100_valid_cnt: got %0d want 3", vcnt); end
    total++; if (last_p !== 8'(E4A_LAST)) begin bad++; $display("FAIL bnd100_period: got %0d want %0d", last_p, E4A_LAST); end
    total++; if (tmo_seen !== 1'b0) begin bad++; $display("FAIL bnd100_timeout: got %b want 0", tmo_seen); end
    mon_reset();
    gen_edges(2, 101);
    total++; if (tmo_seen !== 1'b1) begin bad++; $display("FAIL bnd101_timeout: got %b want 1", tmo_seen); end
    total++; if (vcnt !== 1) begin bad++; $display("FAIL bnd101_valid_cnt: got %0d want 1", vcnt); end
    total++; if (last_p !== 8'(E4B_LAST)) begin bad++; $display("FAIL bnd101_period: got %0d want %0d", last_p, E4B_LAST); end
  endtask

  task automatic test_clear_rise();
    gen_edges(3, 20);
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL clr_pre_locked: got %b want 1", locked); end
    mon_reset();
    sig_in = 1'b1;
    tick(2);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    total++; if (period !== 8'd0) begin bad++; $display("FAIL clr_period: got %0d want 0", period); end
    total++; if (period_valid !== 1'b0) begin bad++; $display("FAIL clr_valid: got %b want 0", period_valid); end
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL clr_locked: got %b want 0", locked); end
    total++; if (timeout !== 1'b0) begin bad++; $display("FAIL clr_timeout: got %b want 0", timeout); end
    tick(7);
    sig_in = 1'b0;
    tick(10);
    gen_edges(2, 20);
    total++; if (vcnt !== 1) begin bad++; $display("FAIL clr_after_valid_cnt: got %0d want 1", vcnt); end
    total++; if (last_p !== 8'd20) begin bad++; $display("FAIL clr_after_period: got %0d want 20", last_p); end
  endtask

  task automatic test_async_reset();
    tick(5);
    #2;
    rst = 1'b1;
    #1;
    total++; if (period !== 8'd0) begin bad++; $display("FAIL arst_period: got %0d want 0", period); end
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL arst_locked: got %b want 0", locked); end
    total++; if (period_valid !== 1'b0) begin bad++; $display("FAIL arst_valid: got %b want 0", period_valid); end
    total++; if (timeout !== 1'b0) begin bad++; $display("FAIL arst_timeout: got %b want 0", timeout); end
    @(posedge clk);
    #1;
    tick(1);
    rst = 1'b0;
    tick(2);
    mon_reset();
    gen_edges(1, 30);
    total++; if (vcnt !== 0) begin bad++; $display("FAIL arst_first_edge_valids: got %0d want 0", vcnt); end
    gen_edges(1, 30);
    total++; if (vcnt !== 1) begin bad++; $display("FAIL arst_valid_cnt: got %0d want 1", vcnt); end
    total++; if (last_p !== 8'd30) begin bad++; $display("FAIL arst_period30: got %0d want 30", last_p); end
  endtask

`ifdef PERIOD_AVG_EN
  task automatic test_average();
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    tick(3);
    mon_reset();
    gen_edges(4, 20);
    tick(20);
    gen_edges(1, 20);
    total++; if (vcnt !== 4) begin bad++; $display("FAIL avg_valid_cnt: got %0d want 4", vcnt); end
    total++; if (vlog[0] !== 8'd20) begin bad++; $display("FAIL avg_p0: got %0d want 20", vlog[0]); end
    total++; if (vlog[1] !== 8'd20) begin bad++; $display("FAIL avg_p1: got %0d want 20", vlog[1]); end
    total++; if (vlog[2] !== 8'd20) begin bad++; $display("FAIL avg_p2: got %0d want 20", vlog[2]); end
    total++; if (vlog[3] !== 8'd25) begin bad++; $display("FAIL avg_p3: got %0d want 25", vlog[3]); end
  endtask
`endif

  initial begin
    rst = 1'b1; sig_in = 1'b0; clear = 1'b0;
    test_reset();
    test_square20();
    test_change37();
    test_timeout();
    test_boundary();
    test_clear_rise();
    test_async_reset();
`ifdef PERIOD_AVG_EN
    test_average();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute guard so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
